// File: rtl/alu_dispatch_mc.sv
// Multi-channel FIFO dispatcher feeding a round-robin
// arbitrated single-cycle ALU with a registered result.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   in_valid/ready  per-channel push handshake
//   in_op/a/b       per-channel packed packet fields
//   out_valid/ready registered result handshake
//   out_data/ch     result and issuing channel
//   out_cout/overflow/zero  ALU status flags
module alu_dispatch_mc #(
  parameter int W     = 8,
  parameter int CH    = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH-1:0]           in_valid,
  output logic [CH-1:0]           in_ready,
  input  logic [2*CH-1:0]         in_op,
  input  logic [W*CH-1:0]         in_a,
  input  logic [W*CH-1:0]         in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic [$clog2(CH)-1:0]   out_ch,
  output logic                    out_cout,
  output logic                    out_overflow,
  output logic                    out_zero
);

  localparam int CW = $clog2(CH);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]   op_mem [CH][DEPTH];
  logic [W-1:0] a_mem  [CH][DEPTH];
  logic [W-1:0] b_mem  [CH][DEPTH];

  logic [AW-1:0] wptr_q [CH];
  logic [AW-1:0] rptr_q [CH];
  logic [AW:0]   cnt_q  [CH];
  logic [CW-1:0] rr_q;

  logic [CH-1:0] push;
  logic [CH-1:0] nonempty;
  logic [CH-1:0] pop_vec;

  logic          gnt_any;
  logic [CW-1:0] gnt;
  logic          slot_free;
  logic          pop;
  int            idx;

  logic [1:0]   h_op;
  logic [W-1:0] h_a;
  logic [W-1:0] h_b;
  logic [W:0]   sum;
  logic [W:0]   dif;
  logic [W-1:0] res_d;
  logic         cout_d;
  logic         ovf_d;

  logic          valid_q;
  logic [W-1:0]  data_q;
  logic [CW-1:0] ch_q;
  logic          cout_q;
  logic          ovf_q;
  logic          zero_q;

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      in_ready[k] = cnt_q[k] != (AW+1)'(DEPTH);
      nonempty[k] = cnt_q[k] != '0;
      push[k]     = in_valid[k] & in_ready[k];
    end
  end

  // First non-empty channel at or after rr, modulo CH.
  always_comb begin
    gnt_any = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int i = 0; i < CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= CH) idx = idx - CH;
      if (!gnt_any && nonempty[CW'(idx)]) begin
        gnt_any = 1'b1;
        gnt     = CW'(idx);
      end
    end
  end

  assign slot_free = !valid_q | out_ready;
  assign pop       = slot_free & gnt_any;

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      pop_vec[k] = pop && (gnt == CW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (push[k])
          wptr_q[k] <= wptr_q[k] + AW'(1);
        if (pop_vec[k])
          rptr_q[k] <= rptr_q[k] + AW'(1);
        if (push[k] && !pop_vec[k])
          cnt_q[k] <= cnt_q[k] + (AW+1)'(1);
        else if (!push[k] && pop_vec[k])
          cnt_q[k] <= cnt_q[k] - (AW+1)'(1);
      end
    end
  end

  // Payload storage needs no reset; count gates reads.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CH; k++) begin
      if (push[k]) begin
        op_mem[k][wptr_q[k]] <= in_op[2*k +: 2];
        a_mem[k][wptr_q[k]]  <= in_a[W*k +: W];
        b_mem[k][wptr_q[k]]  <= in_b[W*k +: W];
      end
    end
  end

  assign h_op = op_mem[gnt][rptr_q[gnt]];
  assign h_a  = a_mem[gnt][rptr_q[gnt]];
  assign h_b  = b_mem[gnt][rptr_q[gnt]];

  assign sum = {1'b0, h_a} + {1'b0, h_b};
  assign dif = {1'b0, h_a} - {1'b0, h_b};

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    unique case (h_op)
      2'b00: begin
        res_d  = sum[W-1:0];
        cout_d = sum[W];
        ovf_d  = (h_a[W-1] == h_b[W-1]) &&
                 (sum[W-1] != h_a[W-1]);
      end
      2'b01: begin
        res_d  = dif[W-1:0];
        cout_d = dif[W];
        ovf_d  = (h_a[W-1] != h_b[W-1]) &&
                 (dif[W-1] != h_a[W-1]);
      end
      2'b10: res_d = h_a & h_b;
      2'b11: res_d = h_a ^ h_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      rr_q    <= '0;
    end else if (pop) begin
      valid_q <= 1'b1;
      data_q  <= res_d;
      ch_q    <= gnt;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= res_d == '0;
      rr_q    <= (gnt == CW'(CH-1)) ? '0 : gnt + CW'(1);
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_ch       = ch_q;
  assign out_cout     = cout_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

endmodule

// File: tb/tb_alu_dispatch_mc.sv
// Scoreboard bench for alu_dispatch_mc: per-channel
// expected-result queues checked by a negedge monitor.
module tb_alu_dispatch_mc;

  localparam int W     = 8;
  localparam int CH    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 2;

  logic              clk;
  logic              rst;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [2*CH-1:0]   in_op;
  logic [W*CH-1:0]   in_a;
  logic [W*CH-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [CW-1:0]     out_ch;
  logic              out_cout;
  logic              out_overflow;
  logic              out_zero;

  alu_dispatch_mc #(.W(W), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_cout     (out_cout),
    .out_overflow (out_overflow),
    .out_zero     (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  exp_t expq [CH][$];
  int   ordq [$];
  int   wait_cnt [CH];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  function automatic exp_t model(input logic [1:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int m, h, ua, ub, sa, sb, r, s;
    m  = 1 << W;
    h  = 1 << (W-1);
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    e  = '0;
    r  = 0;
    case (op)
      2'd0: begin
        r = ua + ub;
        s = sa + sb;
        e.c = r >= m;
        e.o = (s > h-1) || (s < -h);
      end
      2'd1: begin
        r = ua - ub;
        s = sa - sb;
        e.c = ua < ub;
        e.o = (s > h-1) || (s < -h);
        if (r < 0) r = r + m;
      end
      2'd2: r = ua & ub;
      default: r = ua ^ ub;
    endcase
    e.d = W'(r % m);
    e.z = e.d == '0;
    return e;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int k = 0; k < CH; k++) n += expq[k].size();
    return n;
  endfunction

  task automatic flush();
    for (int k = 0; k < CH; k++) begin
      expq[k].delete();
      wait_cnt[k] = 0;
    end
    ordq.delete();
  endtask

  // Record accepted pushes, then advance one edge.
  task automatic cycle();
    for (int k = 0; k < CH; k++)
      if (in_valid[k] && in_ready[k])
        expq[k].push_back(model(in_op[2*k +: 2],
                                in_a[W*k +: W],
                                in_b[W*k +: W]));
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int k,
                         input logic [1:0] op,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
    in_valid[k]      = 1'b1;
    in_op[2*k +: 2]  = op;
    in_a[W*k +: W]   = a;
    in_b[W*k +: W]   = b;
  endtask

  task automatic rand_pkt(input int k);
    set_pkt(k, 2'($urandom_range(0, 3)),
            W'($urandom), W'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_outputs",
          {out_valid, out_ch, out_data,
           out_cout, out_overflow, out_zero}, 0);
    check("rst_in_ready", in_ready, 4'hF);
    flush();
    in_valid  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("idle_valid", out_valid, 0);
    end
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (pending() == 0 && !out_valid) break;
      cycle();
    end
    check("drain_pending", pending(), 0);
    check("drain_valid", out_valid, 0);
    check("drain_order_left", ordq.size(), 0);
    out_ready = 1'b0;
  endtask

  task automatic single(input int k, input logic [1:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] d,
                        input logic c, input logic o,
                        input logic z);
    out_ready = 1'b0;
    set_pkt(k, op, a, b);
    cycle();
    in_valid = '0;
    check("lat_early_valid", out_valid, 0);
    cycle();
    check("lat_valid", out_valid, 1);
    check("single_ch", out_ch, k);
    check("single_data", out_data, d);
    check("single_flags",
          {out_cout, out_overflow, out_zero}, {c, o, z});
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  logic [31:0] prev_bus;
  logic        hold_prev = 1'b0;
  int          mc;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("hold_stable",
              {out_valid, out_ch, out_data,
               out_cout, out_overflow, out_zero}, prev_bus);
      if (out_valid && out_ready) begin
        mc = int'(out_ch);
        if (expq[mc].size() == 0) begin
          total++;
          $display("FAIL spurious_result: got ch %0d data %0h expected none",
                   mc, out_data);
        end else begin
          me = expq[mc].pop_front();
          check("result",
                {out_data, out_cout, out_overflow, out_zero}, me);
        end
        if (ordq.size() > 0)
          check("rr_order", mc, ordq.pop_front());
        // Bound covers the in-register result and a push
        // recorded one edge before it lands in the FIFO.
        for (int k = 0; k < CH; k++) begin
          if (k == mc || expq[k].size() == 0) begin
            wait_cnt[k] = 0;
          end else begin
            wait_cnt[k]++;
            if (wait_cnt[k] > CH + 1) begin
              total++;
              $display("FAIL starvation: ch %0d waited %0d grants, limit %0d",
                       k, wait_cnt[k], CH + 1);
              wait_cnt[k] = 0;
            end
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_bus  = 32'({out_valid, out_ch, out_data,
                       out_cout, out_overflow, out_zero});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  int acc;
  logic [CH-1:0] snap;

  initial begin
    in_valid  = '0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    flush();
    do_reset();

    single(2, 2'b00, 8'hF0, 8'h20, 8'h10, 1, 0, 0);
    single(2, 2'b01, 8'h80, 8'h01, 8'h7F, 0, 1, 0);
    single(1, 2'b11, 8'h5A, 8'h5A, 8'h00, 0, 0, 1);
    single(0, 2'b01, 8'h01, 8'h02, 8'hFF, 1, 0, 0);
    single(3, 2'b10, 8'hCC, 8'h33, 8'h00, 0, 0, 1);

    // Mid-stream reset with a result held.
    set_pkt(1, 2'b00, 8'h01, 8'h02);
    cycle();
    in_valid = '0;
    set_pkt(3, 2'b00, 8'h05, 8'h06);
    cycle();
    in_valid = '0;
    check("pre_rst_valid", out_valid, 1);
    do_reset();

    // Round-robin from rr = 0.
    for (int r = 0; r < 2; r++) begin
      rand_pkt(0);
      rand_pkt(1);
      rand_pkt(3);
      cycle();
    end
    in_valid = '0;
    ordq = '{0, 1, 3, 0, 1, 3};
    drain();

    // Backpressure.
    for (int r = 0; r < 2; r++) begin
      rand_pkt(0);
      rand_pkt(2);
      cycle();
    end
    in_valid = '0;
    cycle();
    check("bp_valid", out_valid, 1);
    snap = in_ready;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_in_ready", in_ready, snap);
    end
    drain();

    // Move ch1 pointers off zero so the fill wraps.
    rand_pkt(1);
    cycle();
    cycle();
    in_valid = '0;
    drain();

    // Fill ch1 behind a stalled ch0 result.
    rand_pkt(0);
    cycle();
    in_valid = '0;
    cycle();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      rand_pkt(1);
      if (in_ready[1]) acc++;
      cycle();
    end
    in_valid = '0;
    check("full_accepted", acc, DEPTH);
    check("full_ready", in_ready[1], 0);
    out_ready = 1'b1;
    cycle();
    check("full_pop_ready", in_ready[1], 1);
    drain();

    for (int i = 0; i < 4; i++) begin
      rand_pkt(1);
      cycle();
    end
    in_valid = '0;
    drain();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 1) == 1) rand_pkt(k);
        else in_valid[k] = 1'b0;
      end
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_dispatch_mc.md
# alu_dispatch_mc

Multi-channel operand dispatcher with built-in arithmetic unit: the parametrised successor of the single-stream FIFO-to-ALU control path. Each of `CH` input channels owns a `DEPTH`-entry FIFO of {opcode, operand A, operand B} packets. A round-robin arbiter drains one packet per cycle into a single-cycle ALU stage. Results leave through a registered valid/ready output tagged with the originating channel and status flags.

## Interface
Parameters:
- `W`, 8, operand/result width (≥2)
- `CH`, 4, number of input channels (≥2)
- `DEPTH`, 4, entries per channel FIFO (power of two, ≥2)

Ports (`CW` = $clog2(CH)):
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-low
- `in_valid`  in  CH  per-channel packet valid
- `in_ready`  out  CH  per-channel FIFO not full
- `in_op`  in  2*CH  per-channel opcode; channel k at bits [2k+1:2k]
- `in_a`  in  W*CH  per-channel operand A; channel k at [W*k+W-1:W*k]
- `in_b`  in  W*CH  per-channel operand B, same packing
- `out_valid`  out  1  result register holds a valid result
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  W  result
- `out_ch`  out  CW  channel that issued the packet
- `out_cout`  out  1  carry (add) / borrow (sub)
- `out_overflow`  out  1  signed overflow
- `out_zero`  out  1  `out_data` == 0

## Operation
- Push: channel k stores {in_op, in_a, in_b} when `in_valid[k] & in_ready[k]` at an edge. `in_ready[k]` = count[k] != DEPTH; it depends only on registered state, never on `in_valid` or on a same-cycle pop. Ignored when `in_ready[k]`=0 (the packet is not stored).
- FIFO: write/read pointers of $clog2(DEPTH) bits wrap from DEPTH-1 to 0; count 0..DEPTH. Push and pop in the same cycle on a non-empty, non-full FIFO leave the count unchanged.
- Issue condition: `slot_free` = !out_valid | out_ready. When `slot_free` and at least one FIFO is non-empty, the arbiter grants exactly one channel, pops its head, and loads the result register.
- Round-robin: a priority pointer `rr` (reset 0) marks the highest-priority channel. The grant goes to the first non-empty channel searching rr, rr+1, … mod CH. After a grant to channel g, rr = (g+1) mod CH. rr is unchanged when there is no grant.
- ALU (A, B unsigned W-bit):
  - op 00: add. out_data = A+B mod 2^W; cout = carry out; overflow = signed overflow of A+B.
  - op 01: sub. out_data = A-B mod 2^W; cout = 1 iff A<B unsigned; overflow = signed overflow of A-B.
  - op 10: and; op 11: xor. cout = 0 and overflow = 0 for both.
  - zero = (out_data == 0) for every op.
- Output hold: while `out_valid & !out_ready`, all `out_*` stay stable and no pop occurs.
- Reset (asynchronous, any time, including mid-transfer): all FIFOs empty, pointers 0, rr = 0, and every output is 0 (`out_valid`, `out_data`, `out_ch`, `out_cout`, `out_overflow`, `out_zero`). `in_ready` becomes all ones, because it derives from count = 0. Packets in flight are discarded.

## Timing
- Latency: a packet pushed at edge N into an empty system reaches an eligible FIFO head after N. It is popped and registered at edge N+1, so `out_valid`=1 during cycle N+1. There is no input-to-output combinational path.
- Throughput: one result per cycle while `out_ready`=1 and any FIFO is non-empty.
- Handshake: a result transfers at an edge where `out_valid & out_ready`. The next result, if any, loads at that same edge. Otherwise `out_valid` falls.
- A full FIFO popped at edge N shows `in_ready[k]`=1 in cycle N+1; a push presented in cycle N is refused.
- Simultaneous pushes on all channels in one cycle are all accepted if not full.

## Test plan
- Reset/idle: assert `rst`=0 mid-stream with `out_valid`=1 -> all outputs 0 immediately, `in_ready`=4'b1111; after release with no input, `out_valid` stays 0.
- Single op, W=8: ch2 pushes add A=8'hF0, B=8'h20 at edge N -> at N+1, out_data=8'h10, out_ch=2, cout=1, overflow=0, zero=0. Sub 8'h80-8'h01 -> 8'h7F, cout=0, overflow=1. Xor 8'h5A^8'h5A -> 8'h00, zero=1.
- Round-robin: preload ch0, ch1, ch3 with 2 packets each, `out_ready`=1 -> out_ch sequence 0,1,3,0,1,3 on consecutive cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles with pending data -> outputs frozen and FIFO counts unchanged. Release -> each result is delivered once, none lost or duplicated.
- Full/wrap: push 6 packets into ch1 (DEPTH=4) with output stalled -> 4 accepted, `in_ready[1]`=0 while full. Drain, push 4 more -> FIFO order preserved across pointer wrap.
- Random: all channels random valid/ops, random `out_ready` -> per-channel results match a reference model in order, and no channel starves for more than CH grants.
